udp_builder: RTL and testbench

//  Transmit-side counterpart of the UDP parser: accepts a raw payload byte stream (sof/eof framed),

---
 rtl/udp_builder.sv | 217 +++++++++++++++++++++
 tb/tb_udp_builder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_builder.sv
// -----------------------------------------------------------------------------
// udp_builder
//   Transmit-side frame builder. Buffers one raw payload packet (sof/eof
//   framed) and then emits it as an Ethernet II + IPv4 + UDP frame, one byte
//   per cycle, through a show-ahead FIFO-style read port. No preamble, no FCS
//   and no minimum-length padding are added.
//
// Ports
//   clock        sole clock, rising edge
//   reset        asynchronous, active-low
//   in_din       payload byte
//   in_wr_en     write strobe, ignored while in_full=1
//   in_wr_sof    first payload byte of a packet
//   in_wr_eof    last payload byte of a packet
//   in_full      1 = writes are not accepted (checksum / frame output phase)
//   out_rd_en    pop the current byte, ignored while out_empty=1
//   out_dout     current frame byte, valid while out_empty=0
//   out_rd_sof   out_dout is frame byte 0
//   out_rd_eof   out_dout is the last frame byte
//   out_empty    1 = no byte available
//   drop_count   number of oversize packets discarded, saturating
// -----------------------------------------------------------------------------
module udp_builder #(
    parameter int          MAX_PAYLOAD = 1472,
    parameter logic [47:0] DST_MAC     = 48'h66778899AABB,
    parameter logic [47:0] SRC_MAC     = 48'h001122334455,
    parameter logic [31:0] SRC_IP      = 32'hC0A80001,
    parameter logic [31:0] DST_IP      = 32'hC0A80002,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] DST_PORT    = 16'd6000,
    parameter logic [7:0]  TTL         = 8'd64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_din,
    input  logic        in_wr_en,
    input  logic        in_wr_sof,
    input  logic        in_wr_eof,
    output logic        in_full,
    input  logic        out_rd_en,
    output logic [7:0]  out_dout,
    output logic        out_rd_sof,
    output logic        out_rd_eof,
    output logic        out_empty,
    output logic [15:0] drop_count
);

    localparam int HDR_BYTES = 42;
    localparam int IDX_W     = $clog2(MAX_PAYLOAD + HDR_BYTES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CSUM, HDR, PAY, DROP} state_t;

    state_t           state;
    logic [7:0]       mem [MAX_PAYLOAD];
    logic [IDX_W-1:0] len;        // payload bytes held in the buffer
    logic [IDX_W-1:0] idx;        // next frame byte to present on the read port
    logic [15:0]      ip_id;
    logic [15:0]      csum;

    logic             wr_acc;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [15:0]      total_len;
    logic [15:0]      udp_len;
    logic [31:0]      sum;
    logic [31:0]      fold1;
    logic [31:0]      fold2;
    logic [15:0]      csum_next;
    logic [7:0]       hdr_bytes [64];
    logic [IDX_W-1:0] frame_len;
    logic [IDX_W-1:0] pay_addr;
    logic [7:0]       next_byte;

    assign in_full   = (state == CSUM) || (state == HDR) || (state == PAY);
    assign wr_acc    = in_wr_en && !in_full;
    assign total_len = 16'(len) + 16'd28;
    assign udp_len   = 16'(len) + 16'd8;
    assign frame_len = len + IDX_W'(HDR_BYTES);
    assign pay_addr  = idx - IDX_W'(HDR_BYTES);

    // Buffer write decode: a sof byte always lands at address 0 (restart),
    // other bytes append while there is room. Overflow bytes are not stored.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        mem_we    = 1'b0;
        mem_waddr = len;
        if (wr_acc) begin
            if ((state == IDLE || state == LOAD) && in_wr_sof) begin
                mem_we    = 1'b1;
                mem_waddr = '0;
            end else if (state == LOAD && len < IDX_W'(MAX_PAYLOAD)) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: the payload buffer has no reset; its contents are only read after being written.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= in_din;
    end

    // IPv4 header checksum with the checksum field taken as zero. The raw sum
    // fits in 20 bits, so two end-around folds always land in 16 bits.
    always_comb begin
        sum = 32'h4500 + 32'(total_len) + 32'(ip_id) + 32'h4000 +
              32'({TTL, 8'h11}) +
              32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) +
              32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
        fold1     = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        fold2     = {16'h0, fold1[15:0]} + {16'h0, fold1[31:16]};
        csum_next = ~fold2[15:0];
    end

    // Fixed 42-byte header image, big-endian fields.
    always_comb begin
        for (int i = 0; i < 64; i++) hdr_bytes[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            hdr_bytes[i]     = DST_MAC[8*(5-i) +: 8];
            hdr_bytes[6 + i] = SRC_MAC[8*(5-i) +: 8];
        end
        hdr_bytes[12] = 8'h08;
        hdr_bytes[13] = 8'h00;
        hdr_bytes[14] = 8'h45;
        hdr_bytes[15] = 8'h00;
        hdr_bytes[16] = total_len[15:8];
        hdr_bytes[17] = total_len[7:0];
        hdr_bytes[18] = ip_id[15:8];
        hdr_bytes[19] = ip_id[7:0];
        hdr_bytes[20] = 8'h40;
        hdr_bytes[21] = 8'h00;
        hdr_bytes[22] = TTL;
        hdr_bytes[23] = 8'h11;
        hdr_bytes[24] = csum[15:8];
        hdr_bytes[25] = csum[7:0];
        for (int i = 0; i < 4; i++) begin
            hdr_bytes[26 + i] = SRC_IP[8*(3-i) +: 8];
            hdr_bytes[30 + i] = DST_IP[8*(3-i) +: 8];
        end
        hdr_bytes[34] = SRC_PORT[15:8];
        hdr_bytes[35] = SRC_PORT[7:0];
        hdr_bytes[36] = DST_PORT[15:8];
        hdr_bytes[37] = DST_PORT[7:0];
        hdr_bytes[38] = udp_len[15:8];
        hdr_bytes[39] = udp_len[7:0];
        hdr_bytes[40] = 8'h00;
        hdr_bytes[41] = 8'h00;
        next_byte = (idx < IDX_W'(HDR_BYTES)) ? hdr_bytes[idx[5:0]] : mem[pay_addr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len        <= '0;
            idx        <= '0;
            ip_id      <= '0;
            csum       <= '0;
            drop_count <= '0;
            out_dout   <= '0;
            out_rd_sof <= 1'b0;
            out_rd_eof <= 1'b0;
            out_empty  <= 1'b1;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (wr_acc && in_wr_sof) begin
                        len   <= IDX_W'(1);
                        state <= in_wr_eof ? CSUM : LOAD;
                    end
                end
                LOAD: begin
                    if (wr_acc) begin
                        if (in_wr_sof) begin
                            len   <= IDX_W'(1);
                            state <= in_wr_eof ? CSUM : LOAD;
                        end else if (len == IDX_W'(MAX_PAYLOAD)) begin
                            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                            state <= in_wr_eof ? IDLE : DROP;
                        end else begin
                            len <= len + IDX_W'(1);
                            if (in_wr_eof) state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    csum  <= csum_next;
                    idx   <= '0;
                    state <= HDR;
                end
                HDR, PAY: begin
                    if (out_rd_en && !out_empty && out_rd_eof) begin
                        // Last byte popped: frame complete.
                        out_empty  <= 1'b1;
                        out_dout   <= '0;
                        out_rd_sof <= 1'b0;
                        out_rd_eof <= 1'b0;
                        ip_id      <= ip_id + 16'd1;
                        state      <= IDLE;
                    end else if (out_empty || out_rd_en) begin
                        // Refill the show-ahead register when empty or being popped.
                        out_dout   <= next_byte;
                        out_rd_sof <= (idx == '0);
                        out_rd_eof <= (idx == frame_len - IDX_W'(1));
                        out_empty  <= 1'b0;
                        idx        <= idx + IDX_W'(1);
                        if (idx == IDX_W'(HDR_BYTES - 1)) state <= PAY;
                    end
                end
                DROP: begin
                    if (wr_acc && in_wr_eof) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_builder.sv
// -----------------------------------------------------------------------------
// tb_udp_builder
//   Directed self-checking bench for udp_builder. Expected frames are built
//   from the payload by a small reference model (header layout + checksum).
// -----------------------------------------------------------------------------
module tb_udp_builder;

    typedef logic [7:0] byte_t;

    logic        clock;
    logic        reset;
    logic [7:0]  in_din;
    logic        in_wr_en;
    logic        in_wr_sof;
    logic        in_wr_eof;
    logic        in_full;
    logic        out_rd_en;
    logic [7:0]  out_dout;
    logic        out_rd_sof;
    logic        out_rd_eof;
    logic        out_empty;
    logic [15:0] drop_count;

    udp_builder dut (
        .clock      (clock),
        .reset      (reset),
        .in_din     (in_din),
        .in_wr_en   (in_wr_en),
        .in_wr_sof  (in_wr_sof),
        .in_wr_eof  (in_wr_eof),
        .in_full    (in_full),
        .out_rd_en  (out_rd_en),
        .out_dout   (out_dout),
        .out_rd_sof (out_rd_sof),
        .out_rd_eof (out_rd_eof),
        .out_empty  (out_empty),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int    errors = 0;
    int    checks = 0;
    byte_t pay[$];
    byte_t exp_q[$];
    byte_t got[$];
    int    sof_pos, eof_pos, sof_cnt, eof_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input byte_t d, input logic sof, input logic eof);
        in_din    = d;
        in_wr_en  = 1'b1;
        in_wr_sof = sof;
        in_wr_eof = eof;
        @(posedge clock); #1;
        in_wr_en  = 1'b0;
        in_wr_sof = 1'b0;
        in_wr_eof = 1'b0;
    endtask

    task automatic send_packet();
        for (int i = 0; i < pay.size(); i++)
            write_byte(pay[i], i == 0, i == pay.size() - 1);
    endtask

    // Reference frame: Ethernet II + IPv4 + UDP header followed by pay.
    task automatic build_expected(input logic [15:0] id);
        logic [15:0] tl, ul, ck;
        logic [31:0] s;
        tl = 16'(28 + pay.size());
        ul = 16'(8 + pay.size());
        s  = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4011 +
             32'hC0A8 + 32'h0001 + 32'hC0A8 + 32'h0002;
        s  = (s & 32'hFFFF) + (s >> 16);
        s  = (s & 32'hFFFF) + (s >> 16);
        ck = ~s[15:0];
        exp_q = '{8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB,
                  8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                  8'h08, 8'h00, 8'h45, 8'h00};
        exp_q.push_back(tl[15:8]); exp_q.push_back(tl[7:0]);
        exp_q.push_back(id[15:8]); exp_q.push_back(id[7:0]);
        exp_q.push_back(8'h40); exp_q.push_back(8'h00);
        exp_q.push_back(8'h40); exp_q.push_back(8'h11);
        exp_q.push_back(ck[15:8]); exp_q.push_back(ck[7:0]);
        exp_q.push_back(8'hC0); exp_q.push_back(8'hA8); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'hC0); exp_q.push_back(8'hA8); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        exp_q.push_back(8'h13); exp_q.push_back(8'h88);
        exp_q.push_back(8'h17); exp_q.push_back(8'h70);
        exp_q.push_back(ul[15:8]); exp_q.push_back(ul[7:0]);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        foreach (pay[i]) exp_q.push_back(pay[i]);
    endtask

    // Pop bytes until eof, max_pop bytes, or the cycle budget expires.
    // mode 0: read every cycle. mode 1: 50% reads plus writes hammering in_full.
    task automatic read_frame(input int mode, input int max_pop, input int budget);
        int cyc;
        bit done;
        got.delete();
        sof_cnt = 0; eof_cnt = 0; sof_pos = -1; eof_pos = -1;
        done = 1'b0; cyc = 0;
        while (!done && got.size() < max_pop && cyc < budget) begin
            out_rd_en = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (mode == 1) begin
                in_wr_en  = 1'($urandom_range(0, 1));
                in_wr_sof = 1'b1;
                in_wr_eof = 1'($urandom_range(0, 1));
                in_din    = 8'($urandom);
            end
            if (out_rd_en && !out_empty) begin
                if (out_rd_sof) begin sof_cnt++; sof_pos = got.size(); end
                if (out_rd_eof) begin eof_cnt++; eof_pos = got.size(); done = 1'b1; end
                got.push_back(out_dout);
            end
            @(posedge clock); #1;
            cyc++;
        end
        out_rd_en = 1'b0;
        in_wr_en  = 1'b0;
        in_wr_sof = 1'b0;
        in_wr_eof = 1'b0;
    endtask

    task automatic compare_frame(input string tag);
        int mism;
        mism = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) mism++;
        check({tag, "_len"}, got.size(), exp_q.size());
        check({tag, "_byte_mismatches"}, mism, 0);
        check({tag, "_sof_pos"}, sof_pos, 0);
        check({tag, "_eof_pos"}, eof_pos, exp_q.size() - 1);
        check({tag, "_sof_cnt"}, sof_cnt, 1);
        check({tag, "_eof_cnt"}, eof_cnt, 1);
    endtask

    function automatic logic [15:0] got_word(input int i);
        byte_t hi, lo;
        hi = (i < got.size()) ? got[i] : 8'h00;
        lo = (i + 1 < got.size()) ? got[i + 1] : 8'h00;
        return {hi, lo};
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        logic [31:0] s;
        reset     = 1'b0;
        in_din    = 8'h00;
        in_wr_en  = 1'b0;
        in_wr_sof = 1'b0;
        in_wr_eof = 1'b0;
        out_rd_en = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Reset state
        check("rst_out_empty", out_empty, 1);
        check("rst_in_full", in_full, 0);
        check("rst_out_dout", out_dout, 0);
        check("rst_sof", out_rd_sof, 0);
        check("rst_eof", out_rd_eof, 0);
        check("rst_drop_count", drop_count, 0);

        // 4-byte payload, latency and full-rate read
        write_byte(8'h11, 1'b0, 1'b0);   // no sof in IDLE: ignored
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_packet();
        check("t1_csum_empty", out_empty, 1);
        check("t1_csum_full", in_full, 1);
        @(posedge clock); #1;
        check("t1_hdr_empty", out_empty, 1);
        @(posedge clock); #1;
        check("t1_first_visible", out_empty, 0);
        check("t1_first_byte", out_dout, 8'h66);
        check("t1_first_sof", out_rd_sof, 1);
        build_expected(16'h0000);
        read_frame(0, 100000, 200);
        compare_frame("t1");
        check("t1_total_len", got_word(16), 16'h0020);
        check("t1_udp_len", got_word(38), 16'h000C);
        check("t1_ip_id", got_word(18), 16'h0000);
        s = 0;
        for (int i = 14; i < 34; i += 2) s += 32'(got_word(i));
        s = (s & 32'hFFFF) + (s >> 16);
        s = (s & 32'hFFFF) + (s >> 16);
        check("t1_hdr_onesum", s, 32'hFFFF);
        check("t1_tail", {got_word(42), got_word(44)}, 32'hDEADBEEF);
        check("t1_done_empty", out_empty, 1);
        check("t1_done_full", in_full, 0);

        // Back-to-back 1-byte and 1472-byte packets
        apply_reset();
        pay = '{8'h5A};
        send_packet();
        build_expected(16'h0000);
        read_frame(0, 100000, 200);
        compare_frame("t2a");
        pay.delete();
        for (int i = 0; i < 1472; i++) pay.push_back(8'(i) ^ 8'hA5);
        send_packet();
        build_expected(16'h0001);
        read_frame(0, 100000, 3000);
        compare_frame("t2b");
        check("t2b_ip_id", got_word(18), 16'h0001);

        // Oversize packet dropped, then 2-byte packet
        apply_reset();
        pay.delete();
        for (int i = 0; i < 1473; i++) pay.push_back(8'(i));
        send_packet();
        check("t3_drop_count", drop_count, 1);
        check("t3_drop_full", in_full, 0);
        repeat (4) @(posedge clock); #1;
        check("t3_no_frame", out_empty, 1);
        pay = '{8'h12, 8'h34};
        send_packet();
        build_expected(16'h0000);
        read_frame(0, 100000, 200);
        compare_frame("t3");

        // Random read enables with writes hammering while in_full
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'($urandom));
        send_packet();
        build_expected(16'h0001);
        read_frame(1, 100000, 2000);
        compare_frame("t4");
        check("t4_drop_count", drop_count, 1);

        // sof mid-LOAD restarts the packet
        write_byte(8'hA1, 1'b1, 1'b0);
        write_byte(8'hA2, 1'b0, 1'b0);
        write_byte(8'hA3, 1'b0, 1'b0);
        pay = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        send_packet();
        build_expected(16'h0002);
        read_frame(0, 100000, 200);
        compare_frame("t5");
        check("t5_udp_len", got_word(38), 16'h000D);

        // Async reset mid-frame
        pay = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        send_packet();
        build_expected(16'h0003);
        read_frame(0, 20, 200);
        check("t6_partial_len", got.size(), 20);
        check("t6_byte20", out_dout, exp_q[20]);
        reset = 1'b0;
        #1;
        check("t6_rst_empty", out_empty, 1);
        check("t6_rst_full", in_full, 0);
        check("t6_rst_dout", out_dout, 0);
        check("t6_rst_drop", drop_count, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_packet();
        build_expected(16'h0000);
        read_frame(0, 100000, 200);
        compare_frame("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
